// File: rtl/cpu_trace_unit.sv
// Per-cycle CPU status trace producer: samples PC and hazard/branch signals,
// keeps running cycle/stall/flush counts and queues 128-bit records in a FIFO.
module cpu_trace_unit #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned MAX_CYCLES = 64
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic [31:0]  pc_i,
    input  logic         stall_i,
    input  logic         branch_i,
    input  logic         flush_i,
    output logic         trace_valid_o,
    input  logic         trace_ready_i,
    output logic [127:0] trace_data_o,
    output logic [31:0]  cycle_o,
    output logic [31:0]  stall_cnt_o,
    output logic [31:0]  flush_cnt_o,
    output logic [15:0]  drop_cnt_o,
    output logic         done_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_e;

    state_e         state_q, state_d;
    logic [AW:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [127:0]   mem_q [DEPTH];
    logic [31:0]    cycle_q, cycle_d;
    logic [31:0]    stall_cnt_q, stall_cnt_d;
    logic [31:0]    flush_cnt_q, flush_cnt_d;
    logic [15:0]    drop_cnt_q, drop_cnt_d;

    logic           sample, empty, full, pop, push;
    logic [31:0]    stall_next, flush_next, cycle_next;
    logic [127:0]   record;

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cycle_d     = cycle_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        drop_cnt_d  = drop_cnt_q;

        // The IDLE->RUN edge is itself a sampling edge
        sample     = start_i && (state_q != HALT);
        empty      = (wr_ptr_q == rd_ptr_q);
        full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop        = !empty && trace_ready_i;
        push       = sample && (!full || pop);

        stall_next = stall_cnt_q + {31'b0, stall_i & ~branch_i};
        flush_next = flush_cnt_q + {31'b0, flush_i};
        cycle_next = cycle_q + 32'd1;
        record     = {cycle_q, pc_i, stall_next, flush_next};

        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        if (sample) begin
            cycle_d     = cycle_next;
            stall_cnt_d = stall_next;
            flush_cnt_d = flush_next;
            state_d     = RUN;
            if (MAX_CYCLES != 0 && cycle_next == 32'(MAX_CYCLES)) begin
                state_d = HALT;
            end
            // Dropped records still advance the counters
            if (!push && drop_cnt_q != 16'hFFFF) begin
                drop_cnt_d = drop_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cycle_q     <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            drop_cnt_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cycle_q     <= cycle_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            if (push) begin
                mem_q[wr_ptr_q[AW-1:0]] <= record;
            end
        end
    end

    assign trace_valid_o = !empty;
    assign trace_data_o  = mem_q[rd_ptr_q[AW-1:0]];
    assign cycle_o       = cycle_q;
    assign stall_cnt_o   = stall_cnt_q;
    assign flush_cnt_o   = flush_cnt_q;
    assign drop_cnt_o    = drop_cnt_q;
    assign done_o        = (state_q == HALT) && empty;

endmodule

// File: tb/tb_cpu_trace_unit.sv
// Directed self-checking bench for cpu_trace_unit; a second instance with
// MAX_CYCLES=8 shares the stimulus and is checked only in the halt scenario.
module tb_cpu_trace_unit;

    logic         clk = 1'b0;
    logic         rst, start, stall, branch, flush, ready;
    logic [31:0]  pc;

    logic         valid_a, done_a, valid_b, done_b;
    logic [127:0] data_a, data_b;
    logic [31:0]  cyc_a, stc_a, flc_a, cyc_b, stc_b, flc_b;
    logic [15:0]  drp_a, drp_b;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    cpu_trace_unit #(.DEPTH(4), .MAX_CYCLES(64)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .pc_i(pc),
        .stall_i(stall), .branch_i(branch), .flush_i(flush),
        .trace_valid_o(valid_a), .trace_ready_i(ready), .trace_data_o(data_a),
        .cycle_o(cyc_a), .stall_cnt_o(stc_a), .flush_cnt_o(flc_a),
        .drop_cnt_o(drp_a), .done_o(done_a)
    );

    cpu_trace_unit #(.DEPTH(4), .MAX_CYCLES(8)) dut_halt (
        .clk_i(clk), .rst_i(rst), .start_i(start), .pc_i(pc),
        .stall_i(stall), .branch_i(branch), .flush_i(flush),
        .trace_valid_o(valid_b), .trace_ready_i(ready), .trace_data_o(data_b),
        .cycle_o(cyc_b), .stall_cnt_o(stc_b), .flush_cnt_o(flc_b),
        .drop_cnt_o(drp_b), .done_o(done_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; ready = 1'b0;
        stall = 1'b0; branch = 1'b0; flush = 1'b0; pc = '0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (valid_a !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %0b want 0", valid_a); end
        vectors++;
        if (data_a !== 128'd0) begin miscompares++; $display("FAIL reset_data got %h want 0", data_a); end
        vectors++;
        if ({cyc_a, stc_a, flc_a, drp_a} !== 112'd0) begin
            miscompares++; $display("FAIL reset_counters got %0d/%0d/%0d/%0d want 0", cyc_a, stc_a, flc_a, drp_a);
        end
        vectors++;
        if (done_a !== 1'b0) begin miscompares++; $display("FAIL reset_done got %0b want 0", done_a); end
        pc = 32'h44; step(); step();
        vectors++;
        if (valid_a !== 1'b0 || cyc_a !== 32'd0) begin
            miscompares++; $display("FAIL idle_no_sample valid %0b cycle %0d want 0 0", valid_a, cyc_a);
        end
    endtask

    task automatic test_basic_run();
        do_reset();
        start = 1'b1; ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            pc = 32'(4 * k);
            step();
            vectors++;
            if (valid_a !== 1'b1 || data_a !== {32'(k), 32'(4 * k), 32'd0, 32'd0} || cyc_a !== 32'(k + 1)) begin
                miscompares++;
                $display("FAIL basic_rec%0d valid %0b data %h cycle %0d want 1 %h %0d", k, valid_a, data_a, cyc_a,
                         {32'(k), 32'(4 * k), 32'd0, 32'd0}, k + 1);
            end
        end
    endtask

    task automatic test_stall_qual();
        logic [2:0] vec [6];  // {stall, branch, flush}
        int exp_s [6];
        int exp_f [6];
        vec   = '{3'b110, 3'b111, 3'b100, 3'b101, 3'b100, 3'b000};
        exp_s = '{0, 0, 1, 2, 3, 3};
        exp_f = '{0, 1, 1, 2, 2, 2};
        do_reset();
        start = 1'b1; ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            {stall, branch, flush} = vec[k];
            pc = 32'h1000 + 32'(4 * k);
            step();
            vectors++;
            if (data_a[63:32] !== 32'(exp_s[k]) || data_a[31:0] !== 32'(exp_f[k])) begin
                miscompares++;
                $display("FAIL stall_rec%0d stall/flush %0d/%0d want %0d/%0d", k, data_a[63:32], data_a[31:0],
                         exp_s[k], exp_f[k]);
            end
        end
        {stall, branch, flush} = 3'b000;
        vectors++;
        if (stc_a !== 32'd3 || flc_a !== 32'd2) begin
            miscompares++; $display("FAIL stall_final got %0d/%0d want 3/2", stc_a, flc_a);
        end
    endtask

    task automatic test_overflow_and_full_pop();
        int exp_head [5];
        exp_head = '{1, 2, 3, 10, 11};
        do_reset();
        start = 1'b1; ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            pc = 32'(4 * k);
            step();
            vectors++;
            if (drp_a !== 16'((k >= 4) ? k - 3 : 0)) begin
                miscompares++; $display("FAIL ovf_drop%0d got %0d want %0d", k, drp_a, (k >= 4) ? k - 3 : 0);
            end
        end
        vectors++;
        if (cyc_a !== 32'd10 || data_a !== {32'd0, 32'd0, 32'd0, 32'd0} || valid_a !== 1'b1) begin
            miscompares++; $display("FAIL ovf_state cycle %0d head %h valid %0b want 10 0 1", cyc_a, data_a, valid_a);
        end
        ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            pc = 32'(4 * (10 + j));
            step();
            vectors++;
            if (data_a !== {32'(exp_head[j]), 32'(4 * exp_head[j]), 64'd0} || drp_a !== 16'd6) begin
                miscompares++;
                $display("FAIL fullpop_head%0d got %h drop %0d want cycle %0d drop 6", j, data_a, drp_a, exp_head[j]);
            end
        end
        // FIFO should still hold 11..14: exactly four more pops
        start = 1'b0;
        for (int j = 0; j < 4; j++) begin
            vectors++;
            if (valid_a !== 1'b1 || data_a[127:96] !== 32'(11 + j)) begin
                miscompares++; $display("FAIL drain%0d valid %0b cycle %0d want 1 %0d", j, valid_a, data_a[127:96], 11 + j);
            end
            step();
        end
        vectors++;
        if (valid_a !== 1'b0 || cyc_a !== 32'd15) begin
            miscompares++; $display("FAIL drain_empty valid %0b cycle %0d want 0 15", valid_a, cyc_a);
        end
    endtask

    task automatic test_halt();
        do_reset();
        start = 1'b1; ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            pc = 32'(4 * k);
            step();
            vectors++;
            if (valid_b !== 1'b1 || data_b !== {32'(k), 32'(4 * k), 64'd0}) begin
                miscompares++; $display("FAIL halt_rec%0d valid %0b data %h", k, valid_b, data_b);
            end
        end
        vectors++;
        if (cyc_b !== 32'd8 || done_b !== 1'b0) begin
            miscompares++; $display("FAIL halt_pre cycle %0d done %0b want 8 0", cyc_b, done_b);
        end
        for (int k = 8; k < 12; k++) begin
            pc = 32'(4 * k);
            step();
            vectors++;
            if (valid_b !== 1'b0 || done_b !== 1'b1 || cyc_b !== 32'd8) begin
                miscompares++; $display("FAIL halt_post%0d valid %0b done %0b cycle %0d want 0 1 8", k, valid_b, done_b, cyc_b);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        start = 1'b1; ready = 1'b0;
        pc = 32'h10; step();
        pc = 32'h14; step();
        rst = 1'b1; ready = 1'b1;
        step();
        rst = 1'b0; start = 1'b0;
        vectors++;
        if (valid_a !== 1'b0 || {cyc_a, stc_a, flc_a, drp_a} !== 112'd0 || data_a !== 128'd0) begin
            miscompares++; $display("FAIL midreset valid %0b cycle %0d drop %0d data %h want all 0", valid_a, cyc_a, drp_a, data_a);
        end
        step(); step();
        vectors++;
        if (valid_a !== 1'b0 || cyc_a !== 32'd0) begin
            miscompares++; $display("FAIL midreset_idle valid %0b cycle %0d want 0 0", valid_a, cyc_a);
        end
        start = 1'b1; pc = 32'h100;
        step();
        vectors++;
        if (valid_a !== 1'b1 || data_a !== {32'd0, 32'h100, 64'd0} || cyc_a !== 32'd1) begin
            miscompares++; $display("FAIL midreset_first valid %0b data %h cycle %0d", valid_a, data_a, cyc_a);
        end
    endtask

    initial begin
        test_reset();
        test_basic_run();
        test_stall_qual();
        test_overflow_and_full_pop();
        test_halt();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cpu_trace_unit.md
# cpu_trace_unit

Hardware-side producer of the per-cycle CPU status trace for the pipelined CPU. Once started, it samples the program counter and the hazard/branch control signals every cycle. It keeps running cycle, stall and flush counts, and pushes one 128-bit trace record per cycle into a small FIFO. A downstream consumer drains that FIFO over a valid/ready handshake. It sits beside `CPU` and taps `PC.pc_o`, the hazard unit stall, the ID-stage branch signal and the branch-taken flush.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `MAX_CYCLES`, 64: number of records produced before halting; 0 means never halt.

Ports:
- `clk_i` in 1: clock; all state updates on rising edge.
- `rst_i` in 1: reset; synchronous, active-high.
- `start_i` in 1: run enable; when low in RUN, sampling pauses.
- `pc_i` in 32: current PC (PC register output).
- `stall_i` in 1: hazard-detect stall request.
- `branch_i` in 1: ID-stage control Branch; qualifies stall counting.
- `flush_i` in 1: branch taken, IF/ID flush.
- `trace_valid_o` out 1: FIFO head holds a record.
- `trace_ready_i` in 1: consumer accepts the head this cycle.
- `trace_data_o` out 128: head record; [127:96] cycle, [95:64] pc, [63:32] stall count, [31:0] flush count.
- `cycle_o` out 32: records produced so far.
- `stall_cnt_o` out 32: qualified stalls so far.
- `flush_cnt_o` out 32: flushes so far.
- `drop_cnt_o` out 16: records lost to FIFO full; saturates at 0xFFFF.
- `done_o` out 1: HALT state and FIFO empty.

## Operation
- States:
  - IDLE (after reset): wait for start_i.
  - RUN: sampling.
  - HALT: terminal until reset.
- IDLE→RUN on a rising edge with start_i=1. That same edge is the first sampling edge and produces record 0.
- Sampling edge: a rising edge in RUN (or the IDLE→RUN edge) with start_i=1.
- With start_i=0 in RUN: no sample; all counters hold; FIFO still drains.
- On each sampling edge:
  - s_inc = stall_i & ~branch_i.
  - f_inc = flush_i.
  - The record pushed is {cycle_o, pc_i, stall_cnt_o+s_inc, flush_cnt_o+f_inc}.
  - The counters then take those incremented values.
  - cycle_o increments.
- Stall counting: stall_i with branch_i=1 is not counted. Flushes are counted independently of stalls; both may increment in the same cycle.
- RUN→HALT on the sampling edge where cycle_o becomes MAX_CYCLES (MAX_CYCLES≠0). In HALT: no sampling, counters frozen, FIFO continues draining.
- Counter arithmetic: modulo 2^32 (relevant only with MAX_CYCLES=0). drop_cnt_o saturates.
- FIFO behaviour:
  - Pop occurs when trace_valid_o & trace_ready_i.
  - Push is accepted if the FIFO is not full, or if a pop happens in the same cycle.
  - Otherwise the record is dropped and drop_cnt_o increments. The counters still advance, so they are not rolled back.
- Ordering: strict FIFO. trace_data_o is driven from registered storage at the head pointer and is stable while trace_valid_o=1 and trace_ready_i=0.
- Pointers wrap modulo DEPTH. Full/empty are distinguished by an extra pointer bit or an occupancy count.
- Reset mid-operation:
  - FIFO emptied; all counters, drop count and state cleared.
  - In-flight records are discarded, with no partial pop.

## Timing
- Reset values:
  - trace_valid_o=0, trace_data_o=0.
  - cycle_o, stall_cnt_o, flush_cnt_o, drop_cnt_o all 0.
  - done_o=0, state IDLE.
- Latency:
  - A record sampled at edge k is visible at the head with trace_valid_o=1 immediately after edge k, if the FIFO was empty.
  - Counter outputs update at the same edge.
- Throughput: one record per cycle in, one record per cycle out.
- done_o rises on the edge after which the state is HALT and occupancy is 0.
- rst_i=1 dominates start_i and trace_ready_i on the same edge.

## Test plan
- **Basic run:** reset; start_i=1, trace_ready_i=1; pc_i=4k at edge k; no stall or flush.
  - Record k = {k, 4k, 0, 0}.
  - trace_valid_o high from edge 0 onward.
- **Stall qualification:** stall_i=1 with branch_i=1 for 2 cycles, then stall_i=1 with branch_i=0 for 3 cycles; flush_i pulsed twice, once coincident with a counted stall.
  - Final stall_cnt_o=3, flush_cnt_o=2.
  - Per-record counts step exactly on those edges.
- **Overflow:** DEPTH=4, trace_ready_i=0 for 10 sampling edges.
  - FIFO holds cycles 0..3; drop_cnt_o=6; cycle_o=10.
  - Then trace_ready_i=1: records 0,1,2,3 emerge in order, followed by live records.
- **Full with simultaneous pop:** FIFO full, trace_ready_i=1 on a sampling edge.
  - New record accepted; drop_cnt_o unchanged; occupancy stays 4.
- **Halt:** MAX_CYCLES=8, ready=1.
  - Exactly 8 records (cycles 0..7); state HALT; cycle_o=8.
  - done_o=1 once drained; further start_i or pc_i activity produces no records.
- **Reset mid-run:** 2 records queued, rst_i=1 for one edge.
  - Next cycle: trace_valid_o=0, all counters 0.
  - No record until start_i is high again; next record is {0, pc_i, 0, 0}.
